// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the 8-bit accumulator datapath: fetch/decode/execute
// for NOR, ADD, STA, JCC. State is registered; strobes decode combinationally from state.
module control_unit #(
   parameter logic [1:0] OP_NOR = 2'b00,
   parameter logic [1:0] OP_ADD = 2'b01,
   parameter logic [1:0] OP_STA = 2'b10,
   parameter logic [1:0] OP_JCC = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic [1:0] opcode,
   input  logic       carry,
   output logic       mem_en,
   output logic       mem_we,
   output logic       sel_addr,
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       alu_sel,
   output logic       load_carry,
   output logic       clear_carry,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      ALU    = 2'd3
   } state_t;

   state_t cur, nxt;

   always_ff @(posedge clk) begin
      if (rst)
         cur <= FETCH;
      else if (ce)
         cur <= nxt;
   end

   always_comb begin
      nxt = FETCH;
      case (cur)
         FETCH:  nxt = DECODE;
         DECODE: nxt = EXEC;
         EXEC:   nxt = (opcode == OP_NOR || opcode == OP_ADD) ? ALU : FETCH;
         ALU:    nxt = FETCH;
         default: nxt = FETCH;
      endcase
   end

   // Gating by rst here means a reset mid-instruction suppresses that cycle's write/load.
   always_comb begin
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      sel_addr    = 1'b0;
      load_ir     = 1'b0;
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      load_acc    = 1'b0;
      alu_sel     = 1'b0;
      load_carry  = 1'b0;
      clear_carry = 1'b0;
      if (!rst && ce) begin
         case (cur)
            FETCH: begin
               mem_en = 1'b1;
            end
            DECODE: begin
               load_ir = 1'b1;
               inc_pc  = 1'b1;
            end
            EXEC: begin
               if (opcode == OP_STA) begin
                  mem_en   = 1'b1;
                  mem_we   = 1'b1;
                  sel_addr = 1'b1;
               end else if (opcode == OP_JCC) begin
                  load_pc     = ~carry;
                  clear_carry = carry;
               end else begin
                  mem_en   = 1'b1;
                  sel_addr = 1'b1;
               end
            end
            ALU: begin
               load_acc   = 1'b1;
               alu_sel    = (opcode == OP_ADD);
               load_carry = (opcode == OP_ADD);
            end
            default: ;
         endcase
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle state and strobe vectors against hand-computed tables.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst, ce, carry;
   logic [1:0] opcode;
   logic       mem_en, mem_we, sel_addr, load_ir, inc_pc, load_pc;
   logic       load_acc, alu_sel, load_carry, clear_carry;
   logic [1:0] state;
   logic [9:0] sb;

   int total = 0;
   int bad   = 0;

   // sb = {mem_en, mem_we, sel_addr, load_ir, inc_pc, load_pc, load_acc, alu_sel, load_carry, clear_carry}
   localparam logic [9:0] SB_NONE  = 10'b0000000000;
   localparam logic [9:0] SB_FETCH = 10'b1000000000;
   localparam logic [9:0] SB_DEC   = 10'b0001100000;
   localparam logic [9:0] SB_RD    = 10'b1010000000;
   localparam logic [9:0] SB_STA   = 10'b1110000000;
   localparam logic [9:0] SB_JMP   = 10'b0000010000;
   localparam logic [9:0] SB_CLR   = 10'b0000000001;
   localparam logic [9:0] SB_ADD   = 10'b0000001110;
   localparam logic [9:0] SB_NOR   = 10'b0000001000;

   always #5 clk = ~clk;

   assign sb = {mem_en, mem_we, sel_addr, load_ir, inc_pc, load_pc,
                load_acc, alu_sel, load_carry, clear_carry};

   control_unit dut (
      .clk(clk), .rst(rst), .ce(ce), .opcode(opcode), .carry(carry),
      .mem_en(mem_en), .mem_we(mem_we), .sel_addr(sel_addr), .load_ir(load_ir),
      .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .alu_sel(alu_sel),
      .load_carry(load_carry), .clear_carry(clear_carry), .state(state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (state !== 2'd0 || sb !== SB_NONE) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got state=%0d sb=%b exp state=0 sb=%b", i, state, sb, SB_NONE);
         end
      end
      rst = 1'b0; #1;
      total++;
      if (sb !== SB_FETCH) begin
         bad++;
         $display("FAIL reset_release_fetch got sb=%b exp %b", sb, SB_FETCH);
      end
      tick();
      total++;
      if (state !== 2'd1 || sb !== SB_DEC) begin
         bad++;
         $display("FAIL reset_then_decode got state=%0d sb=%b exp state=1 sb=%b", state, sb, SB_DEC);
      end
      rst = 1'b1; tick(); rst = 1'b0; #1;
   endtask

   task automatic test_alu_op(input logic [1:0] op, input logic [9:0] alu_sb);
      logic [1:0] es [4];
      logic [9:0] eb [4];
      es = '{2'd0, 2'd1, 2'd2, 2'd3};
      eb = '{SB_FETCH, SB_DEC, SB_RD, alu_sb};
      opcode = op;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (state !== es[i] || sb !== eb[i]) begin
            bad++;
            $display("FAIL alu_op%0d cyc=%0d got state=%0d sb=%b exp state=%0d sb=%b", op, i, state, sb, es[i], eb[i]);
         end
         tick();
      end
      total++;
      if (state !== 2'd0) begin
         bad++;
         $display("FAIL alu_op%0d_return got state=%0d exp 0", op, state);
      end
   endtask

   task automatic test_three_cycle(input logic [1:0] op, input logic c, input logic [9:0] ex_sb);
      logic [1:0] es [3];
      logic [9:0] eb [3];
      es = '{2'd0, 2'd1, 2'd2};
      eb = '{SB_FETCH, SB_DEC, ex_sb};
      opcode = op; carry = c;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (state !== es[i] || sb !== eb[i]) begin
            bad++;
            $display("FAIL op%0d_c%0d cyc=%0d got state=%0d sb=%b exp state=%0d sb=%b", op, c, i, state, sb, es[i], eb[i]);
         end
         tick();
      end
      total++;
      if (state !== 2'd0) begin
         bad++;
         $display("FAIL op%0d_c%0d_return got state=%0d exp 0", op, c, state);
      end
      carry = 1'b0;
   endtask

   task automatic test_ce_and_mid_reset;
      opcode = 2'b01;
      tick(); tick();
      total++;
      if (state !== 2'd2) begin
         bad++;
         $display("FAIL ce_reach_exec got state=%0d exp 2", state);
      end
      ce = 1'b0; #1;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (state !== 2'd2 || sb !== SB_NONE) begin
            bad++;
            $display("FAIL ce_hold cyc=%0d got state=%0d sb=%b exp state=2 sb=%b", i, state, sb, SB_NONE);
         end
         tick();
      end
      ce = 1'b1; #1;
      total++;
      if (state !== 2'd2 || sb !== SB_RD) begin
         bad++;
         $display("FAIL ce_resume got state=%0d sb=%b exp state=2 sb=%b", state, sb, SB_RD);
      end
      tick();
      total++;
      if (state !== 2'd3 || sb !== SB_ADD) begin
         bad++;
         $display("FAIL pre_mid_reset got state=%0d sb=%b exp state=3 sb=%b", state, sb, SB_ADD);
      end
      rst = 1'b1; #1;
      total++;
      if (state !== 2'd3 || sb !== SB_NONE) begin
         bad++;
         $display("FAIL mid_reset_suppress got state=%0d sb=%b exp state=3 sb=%b", state, sb, SB_NONE);
      end
      tick();
      rst = 1'b0; #1;
      total++;
      if (state !== 2'd0 || sb !== SB_FETCH) begin
         bad++;
         $display("FAIL mid_reset_after got state=%0d sb=%b exp state=0 sb=%b", state, sb, SB_FETCH);
      end
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; carry = 1'b0; opcode = 2'b00;
      test_reset();
      test_alu_op(2'b01, SB_ADD);
      test_alu_op(2'b00, SB_NOR);
      test_three_cycle(2'b10, 1'b0, SB_STA);
      test_three_cycle(2'b11, 1'b0, SB_JMP);
      test_three_cycle(2'b11, 1'b1, SB_CLR);
      test_alu_op(2'b01, SB_ADD);
      test_three_cycle(2'b11, 1'b1, SB_CLR);
      test_ce_and_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
